// File: rtl/sumsq_frame_accum_if.sv
// Bundle between the squarer-side producer and the sum-of-squares frame accumulator.
// The master drives squarer data/qualifiers; the slave returns frame results and status.
interface sumsq_frame_accum_if #(
    parameter int unsigned ACC_W = 48
);
    logic             in_valid;
    logic [31:0]      square;
    logic             clear;
    logic [ACC_W-1:0] sum;
    logic             sum_valid;
    logic [15:0]      sample_cnt;
    logic             overflow;

    modport master (
        output in_valid,
        output square,
        output clear,
        input  sum,
        input  sum_valid,
        input  sample_cnt,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  square,
        input  clear,
        output sum,
        output sum_valid,
        output sample_cnt,
        output overflow
    );
endinterface

// File: rtl/sumsq_frame_accum.sv
// Frame accumulator behind a fixed-latency squarer: tracks square validity with a delay line,
// sums FRAME_LEN valid squares with saturation, and publishes each frame sum with a one-cycle pulse.
module sumsq_frame_accum #(
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned ACC_W     = 48
) (
    input  logic                clk_i,
    input  logic                rst_i,
    sumsq_frame_accum_if.slave  acc_if
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    localparam int unsigned      PAD_W    = ACC_W - 31;
    localparam logic [15:0]      LAST_CNT = 16'(FRAME_LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

    state_e             state_q;
    state_e             state_d;
    logic [LATENCY-1:0] dl_q;
    logic [LATENCY-1:0] dl_d;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [ACC_W-1:0]   sum_q;
    logic [ACC_W-1:0]   sum_d;
    logic [15:0]        cnt_q;
    logic [15:0]        cnt_d;
    logic               sum_valid_q;
    logic               sum_valid_d;
    logic               ovf_q;
    logic               ovf_d;

    logic               sq_valid_s;
    logic               last_s;
    logic               sat_s;
    logic [ACC_W-1:0]   acc_op_s;
    logic [ACC_W:0]     add_ext_s;
    logic [ACC_W-1:0]   add_s;

    // The extra carry bit of the adder is the saturation detector.
    assign sq_valid_s = dl_q[LATENCY-1];
    assign last_s     = (cnt_q == LAST_CNT);
    assign acc_op_s   = (state_q == ST_ACCUM) ? acc_q : ACC_ZERO;
    assign add_ext_s  = {1'b0, acc_op_s} + {{PAD_W{1'b0}}, acc_if.square};
    assign sat_s      = add_ext_s[ACC_W];
    assign add_s      = sat_s ? ACC_MAX : add_ext_s[ACC_W-1:0];

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a valid square on the last count closes the frame; clear always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (acc_if.clear) begin
            state_d = ST_IDLE;
        end else if (sq_valid_s) begin
            case (state_q)
                ST_IDLE:  state_d = last_s ? ST_IDLE : ST_ACCUM;
                ST_ACCUM: state_d = last_s ? ST_IDLE : ST_ACCUM;
                default:  state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Datapath next values: delay line, accumulate, frame completion and sticky overflow.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
        ovf_d       = ovf_q;
        dl_d        = {LATENCY{1'b0}};
        dl_d[0]     = acc_if.in_valid;
        for (int i = 1; i < int'(LATENCY); i++) begin
            dl_d[i] = dl_q[i-1];
        end
        if (acc_if.clear) begin
            acc_d = ACC_ZERO;
            cnt_d = 16'd0;
            dl_d  = {LATENCY{1'b0}};
            ovf_d = 1'b0;
        end else if (sq_valid_s) begin
            ovf_d = ovf_q | sat_s;
            if (last_s) begin
                sum_d       = add_s;
                sum_valid_d = 1'b1;
                acc_d       = ACC_ZERO;
                cnt_d       = 16'd0;
            end else begin
                acc_d = add_s;
                cnt_d = cnt_q + 16'd1;
            end
        end else begin
            acc_d = acc_q;
            cnt_d = cnt_q;
        end
    end

    // Datapath registers; reset additionally zeroes the published sum.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dl_q        <= {LATENCY{1'b0}};
            acc_q       <= ACC_ZERO;
            cnt_q       <= 16'd0;
            sum_q       <= ACC_ZERO;
            sum_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            dl_q        <= dl_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign acc_if.sum        = sum_q;
    assign acc_if.sum_valid  = sum_valid_q;
    assign acc_if.sample_cnt = cnt_q;
    assign acc_if.overflow   = ovf_q;

endmodule

// File: tb/tb_sumsq_frame_accum.sv
// Scoreboard bench: two accumulator instances fed by a behavioural 4-stage squarer; expected frame
// results are queued when a frame's last sample is issued and popped by monitors on each sum_valid.
module tb_sumsq_frame_accum;

    localparam int unsigned LAT = 4;

    typedef struct packed {
        logic [63:0] sum;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    logic [15:0] xa;
    logic [15:0] xb;
    logic [15:0] pa [LAT];
    logic [15:0] pb [LAT];

    always #5 clk = ~clk;

    sumsq_frame_accum_if #(.ACC_W(33)) if_a ();
    sumsq_frame_accum_if #(.ACC_W(48)) if_b ();

    sumsq_frame_accum #(.LATENCY(LAT), .FRAME_LEN(4), .ACC_W(33)) dut_a (
        .clk_i  (clk),
        .rst_i  (rst),
        .acc_if (if_a)
    );

    sumsq_frame_accum #(.LATENCY(LAT), .FRAME_LEN(16), .ACC_W(48)) dut_b (
        .clk_i  (clk),
        .rst_i  (rst),
        .acc_if (if_b)
    );

    // behavioural squarer: X sampled at an edge appears squared LAT cycles later
    always @(posedge clk) begin
        pa[0] <= xa;
        pb[0] <= xb;
        for (int i = 1; i < int'(LAT); i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
        end
    end
    assign if_a.square = 32'(pa[LAT-1]) * 32'(pa[LAT-1]);
    assign if_b.square = 32'(pb[LAT-1]) * 32'(pb[LAT-1]);

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step_a(input logic v, input logic [15:0] x, input logic clr);
        if_a.in_valid = v;
        xa            = x;
        if_a.clear    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic v, input logic [15:0] x, input logic clr);
        if_b.in_valid = v;
        xb            = x;
        if_b.clear    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) step_a(1'b0, 16'd7, 1'b0);
    endtask

    task automatic idle_b(input int n);
        for (int i = 0; i < n; i++) step_b(1'b0, 16'd7, 1'b0);
    endtask

    task automatic push_a(input logic [63:0] s, input logic o);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        e.cyc = cyc + int'(LAT) + 1;
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic [63:0] s, input logic o);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        e.cyc = cyc + int'(LAT) + 1;
        q_b.push_back(e);
    endtask

    initial begin : mon_a
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_a.sum_valid === 1'b1) begin
                if (q_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_pulse: got sum=%0d expected no pulse", if_a.sum);
                end else begin
                    e = q_a.pop_front();
                    check("a_sum", 64'(if_a.sum), e.sum);
                    check("a_ovf_at_pulse", 64'(if_a.overflow), 64'(e.ovf));
                    check("a_pulse_cycle", 64'(cyc), 64'(e.cyc));
                    check("a_cnt_at_pulse", 64'(if_a.sample_cnt), 64'd0);
                end
            end
        end
    end

    initial begin : mon_b
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_b.sum_valid === 1'b1) begin
                if (q_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_pulse: got sum=%0d expected no pulse", if_b.sum);
                end else begin
                    e = q_b.pop_front();
                    check("b_sum", 64'(if_b.sum), e.sum);
                    check("b_ovf_at_pulse", 64'(if_b.overflow), 64'(e.ovf));
                    check("b_pulse_cycle", 64'(cyc), 64'(e.cyc));
                    check("b_cnt_at_pulse", 64'(if_b.sample_cnt), 64'd0);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        xa = 16'd0;
        xb = 16'd0;
        if_a.in_valid = 1'b0;
        if_a.clear    = 1'b0;
        if_b.in_valid = 1'b0;
        if_b.clear    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_a_sum", 64'(if_a.sum), 64'd0);
        check("rst_a_sum_valid", 64'(if_a.sum_valid), 64'd0);
        check("rst_a_cnt", 64'(if_a.sample_cnt), 64'd0);
        check("rst_a_ovf", 64'(if_a.overflow), 64'd0);
        check("rst_b_sum", 64'(if_b.sum), 64'd0);

        // X=1,2,3,4 back to back: 1+4+9+16 = 30
        step_a(1'b1, 16'd1, 1'b0);
        step_a(1'b1, 16'd2, 1'b0);
        @(negedge clk);
        check("t1_cnt_mid", 64'(if_a.sample_cnt), 64'd0);
        step_a(1'b1, 16'd3, 1'b0);
        push_a(64'd30, 1'b0);
        step_a(1'b1, 16'd4, 1'b0);
        idle_a(8);
        @(negedge clk);
        check("t1_sum_held", 64'(if_a.sum), 64'd30);

        // same frame with a 3-cycle gap carrying garbage X=9
        step_a(1'b1, 16'd1, 1'b0);
        step_a(1'b1, 16'd2, 1'b0);
        repeat (3) step_a(1'b0, 16'd9, 1'b0);
        step_a(1'b1, 16'd3, 1'b0);
        push_a(64'd30, 1'b0);
        step_a(1'b1, 16'd4, 1'b0);
        idle_a(8);

        // clear after X=5,6 accumulated; in_valid during clear must be dropped
        step_a(1'b1, 16'd5, 1'b0);
        step_a(1'b1, 16'd6, 1'b0);
        idle_a(6);
        @(negedge clk);
        check("t5_cnt_before_clear", 64'(if_a.sample_cnt), 64'd2);
        step_a(1'b1, 16'd100, 1'b1);
        idle_a(6);
        @(negedge clk);
        check("t5_cnt_after_clear", 64'(if_a.sample_cnt), 64'd0);
        check("t5_sum_held", 64'(if_a.sum), 64'd30);
        step_a(1'b1, 16'd1, 1'b0);
        step_a(1'b1, 16'd1, 1'b0);
        step_a(1'b1, 16'd1, 1'b0);
        push_a(64'd4, 1'b0);
        step_a(1'b1, 16'd1, 1'b0);
        idle_a(1);
        @(negedge clk);
        check("t5_sum_held_until_pulse", 64'(if_a.sum), 64'd30);
        idle_a(8);

        // reset mid-frame with two squares in flight
        step_a(1'b1, 16'd5, 1'b0);
        idle_a(6);
        @(negedge clk);
        check("t6_cnt_before_rst", 64'(if_a.sample_cnt), 64'd1);
        step_a(1'b1, 16'd9, 1'b0);
        step_a(1'b1, 16'd9, 1'b0);
        rst = 1'b1;
        step_a(1'b1, 16'd9, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_sum", 64'(if_a.sum), 64'd0);
        check("t6_rst_sum_valid", 64'(if_a.sum_valid), 64'd0);
        check("t6_rst_cnt", 64'(if_a.sample_cnt), 64'd0);
        check("t6_rst_ovf", 64'(if_a.overflow), 64'd0);
        idle_a(8);
        @(negedge clk);
        check("t6_cnt_after_flight", 64'(if_a.sample_cnt), 64'd0);
        step_a(1'b1, 16'd2, 1'b0);
        step_a(1'b1, 16'd2, 1'b0);
        step_a(1'b1, 16'd2, 1'b0);
        push_a(64'd16, 1'b0);
        step_a(1'b1, 16'd2, 1'b0);
        idle_a(8);

        // 33-bit accumulator saturates on the third 65535^2
        step_a(1'b1, 16'd65535, 1'b0);
        step_a(1'b1, 16'd65535, 1'b0);
        step_a(1'b1, 16'd65535, 1'b0);
        push_a(64'd8589934591, 1'b1);
        step_a(1'b1, 16'd65535, 1'b0);
        idle_a(8);
        idle_a(10);
        @(negedge clk);
        check("t4_ovf_sticky", 64'(if_a.overflow), 64'd1);
        step_a(1'b0, 16'd7, 1'b1);
        @(negedge clk);
        check("t4_ovf_cleared", 64'(if_a.overflow), 64'd0);
        check("t4_sum_held_after_clear", 64'(if_a.sum), 64'd8589934591);

        // FRAME_LEN=16, two back-to-back full-scale frames: 16*4294836225 each
        for (int i = 0; i < 32; i++) begin
            if (i == 15 || i == 31) push_b(64'd68717379600, 1'b0);
            step_b(1'b1, 16'd65535, 1'b0);
        end
        idle_b(10);
        @(negedge clk);
        check("b_ovf_clear", 64'(if_b.overflow), 64'd0);
        check("b_cnt_idle", 64'(if_b.sample_cnt), 64'd0);

        check("a_missing_pulses", 64'(q_a.size()), 64'd0);
        check("b_missing_pulses", 64'(q_b.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sumsq_frame_accum.md
# sumsq_frame_accum

Downstream consumer of the 16-bit pipelined squarer. It tracks which squarer outputs are valid, using a valid-bit delay line matched to the squarer's fixed latency. It accumulates FRAME_LEN valid squares into a wide sum and emits the frame's sum of squares with a one-cycle valid pulse, providing the energy/mean-square stage that follows the squarer in the datapath.

## Interface
- LATENCY, 4, squarer pipeline depth in cycles (1..8); input X sampled at edge t appears on `square` during cycle t+LATENCY
- FRAME_LEN, 16, valid squares per frame (1..65535)
- ACC_W, 48, accumulator/sum width (33..64)
- Clock  in  1  single clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; clears all state
- in_valid  in  1  high in the cycle a valid X is presented to the squarer
- square  in  32  squarer output, unsigned
- clear  in  1  synchronous frame abort; restarts accumulation
- sum  out  ACC_W  last completed frame sum, held until next frame completes
- sum_valid  out  1  one-cycle pulse when `sum` updates
- sample_cnt  out  16  valid squares accumulated in current frame
- overflow  out  1  sticky: accumulator saturated in some frame since last Reset/clear

## Operation
- Valid delay line: LATENCY-bit shift register, shifts in `in_valid` every cycle; its output `sq_valid` marks `square` as valid this cycle.
- States: IDLE (sample_cnt==0, acc==0) and ACCUM (0<sample_cnt<FRAME_LEN).
  - IDLE, sq_valid: acc<=square, cnt<=1 -> ACCUM; if FRAME_LEN==1, emit immediately, stay IDLE.
  - ACCUM, sq_valid, cnt<FRAME_LEN-1: acc<=acc+square, cnt++.
  - ACCUM, sq_valid, cnt==FRAME_LEN-1: sum<=acc+square, sum_valid<=1, acc<=0, cnt<=0 -> IDLE.
  - sq_valid low: hold acc and cnt (gaps allowed anywhere).
- Arithmetic: unsigned, square zero-extended to ACC_W+1 bits. If the sum exceeds 2^ACC_W-1, the result is all-ones (saturate) and overflow<=1. The saturated value carries through the rest of the frame and into `sum`.
- clear: acc<=0, cnt<=0, delay line<=0, overflow<=0, state IDLE. It discards squares already in flight. `sum` is held, and sum_valid is forced 0 that cycle. clear has priority over any completion in the same cycle.
- Reset: same as clear, plus sum<=0. Legal mid-frame; the partial frame is discarded.
- in_valid asserted during the same cycle as clear/Reset is dropped. It is not entered into the delay line.

## Timing
- Reset values: sum=0, sum_valid=0, sample_cnt=0, overflow=0, delay line all 0.
- All outputs registered; no combinational path from inputs to outputs.
- The final sample of a frame has in_valid at cycle t. Its square is accumulated at the edge ending cycle t+LATENCY. sum/sum_valid are visible in cycle t+LATENCY+1.
- sum_valid is high exactly one cycle per completed frame. Back-to-back frames with in_valid held high give one pulse every FRAME_LEN cycles, with no dead cycle between frames.
- sample_cnt reflects accumulations through the previous edge. It reads 0 in the cycle sum_valid is high.
- Throughput is one square per cycle.

## Test plan
- FRAME_LEN=4, LATENCY=4: X=1,2,3,4 on consecutive cycles with in_valid=1 -> sum=30, sum_valid a single pulse 5 cycles after X=4 is presented, sample_cnt returns to 0.
- Same X values with in_valid low for 3 cycles between X=2 and X=3 -> sum=30, pulse delayed by 3 cycles; squares presented while in_valid is low are ignored.
- FRAME_LEN=16, ACC_W=48: X=65535 continuous for 32 cycles -> two pulses 16 cycles apart, each sum=68717379600, overflow=0.
- ACC_W=33, FRAME_LEN=4: X=65535 ×4 -> sum=2^33-1 (saturated), overflow=1 and sticky until clear.
- clear asserted after 2 of 4 valid samples (X=5,6), then X=1,1,1,1 -> sum=4; the earlier 25+36 is lost; the previous `sum` is held until the pulse.
- Reset mid-frame with 2 squares in flight -> all outputs 0 the next cycle; the in-flight squares are not accumulated; the next full frame of X=2 ×4 gives sum=16.
